axi_axis2bram: RTL and testbench

AXI4-Stream to BRAM writer: accepts a fixed-length stream of beats on a slave AXI4-Stream port and writes each beat to consecutive BRAM addresses starting at 0. It is the receive-side counterpart of the BRAM-to-stream reader in the `src/axi` data-movement layer. It uses the same start/done control handshake and byte-count sizing, so host DMA streams can be landed into on-chip buffers.

---
 rtl/axi_axis2bram.sv | 183 ++++++++++++++++++
 tb/tb_axi_axis2bram.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_axis2bram.sv
// AXI4-Stream to BRAM writer: lands a fixed-length stream at consecutive BRAM addresses from 0.
// Optional tlast checking is enabled by defining AXIS2BRAM_TLAST_CHECK_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; done=1, tready=0
// ST_BUSY  | accepting beats while cnt < depth, one registered write per beat
// ST_FLUSH | final registered write is on the BRAM port; return to idle
module axi_axis2bram #(
    parameter int AXI_DATA_WIDTH      = 512,
    parameter int AXI_XFER_SIZE_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH     = 32,
    parameter int BRAM_DATA_WIDTH     = 512
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_as2b_start,
    output logic                           o_as2b_done,
    input  logic [AXI_XFER_SIZE_WIDTH-1:0] i_as2b_data_size_bytes,
    output logic                           o_as2b_err,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic [AXI_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic                           s_axis_tlast,
    output logic [BRAM_ADDR_WIDTH-1:0]     o_as2b_wraddr,
    output logic [BRAM_DATA_WIDTH-1:0]     o_as2b_wrdata,
    output logic                           o_as2b_wren
);

    localparam int CNT_W  = BRAM_ADDR_WIDTH + 1;
    localparam int BITS_W = AXI_XFER_SIZE_WIDTH + 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [CNT_W-1:0]           depth_q, depth_d;
    logic                       wren_q, wren_d;
    logic [BRAM_ADDR_WIDTH-1:0] wraddr_q, wraddr_d;
    logic [BRAM_DATA_WIDTH-1:0] wrdata_q, wrdata_d;

    logic [BITS_W-1:0]          size_bits;
    logic [CNT_W-1:0]           depth_calc;
    logic [CNT_W-1:0]           depth_m1;
    logic                       start_acc;
    logic                       hs;
    logic                       last_beat;
    logic                       end_xfer;
    logic                       tready;
    logic                       done;

    // Byte count to bits needs three extra bits before the divide so large sizes do not wrap.
    assign size_bits  = {i_as2b_data_size_bytes, 3'b000};
    assign depth_calc = CNT_W'(size_bits / BITS_W'(BRAM_DATA_WIDTH));
    assign depth_m1   = depth_q - CNT_W'(1);

    assign start_acc  = (state_q == ST_IDLE) && i_as2b_start;
    assign hs         = s_axis_tvalid && tready;
    assign last_beat  = (cnt_q == depth_m1);

`ifdef AXIS2BRAM_TLAST_CHECK_EN
    logic err_q, err_d;
    logic tlast_err;

    // An early tlast still lands its beat, then closes the transfer.
    assign tlast_err = hs && (s_axis_tlast != last_beat);
    assign end_xfer  = hs && (last_beat || s_axis_tlast);

    always_comb begin
        err_d = err_q;
        if (start_acc) begin
            err_d = 1'b0;
        end else if (tlast_err) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_as2b_err = err_q;
`else
    logic unused_tlast;

    assign unused_tlast = s_axis_tlast;
    assign end_xfer     = hs && last_beat;
    assign o_as2b_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_as2b_start) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (depth_q == '0) begin
                    state_d = ST_IDLE;
                end else if (end_xfer) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // tready depends only on registers so the upstream sees no combinational path from tvalid.
    always_comb begin
        done   = 1'b0;
        tready = 1'b0;
        unique case (state_q)
            ST_IDLE:  done   = 1'b1;
            ST_BUSY:  tready = (cnt_q < depth_q);
            ST_FLUSH: tready = 1'b0;
            default:  done   = 1'b0;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        depth_d  = depth_q;
        wren_d   = 1'b0;
        wraddr_d = wraddr_q;
        wrdata_d = wrdata_q;
        if (start_acc) begin
            depth_d = depth_calc;
            cnt_d   = '0;
        end
        if (hs) begin
            wren_d   = 1'b1;
            wraddr_d = cnt_q[BRAM_ADDR_WIDTH-1:0];
            wrdata_d = s_axis_tdata;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            depth_q  <= '0;
            wren_q   <= 1'b0;
            wraddr_q <= '0;
            wrdata_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            depth_q  <= depth_d;
            wren_q   <= wren_d;
            wraddr_q <= wraddr_d;
            wrdata_q <= wrdata_d;
        end
    end

    assign o_as2b_done   = done;
    assign s_axis_tready = tready;
    assign o_as2b_wren   = wren_q;
    assign o_as2b_wraddr = wraddr_q;
    assign o_as2b_wrdata = wrdata_q;

endmodule

// File: tb/tb_axi_axis2bram.sv
// Testbench for axi_axis2bram: scenario tasks with inline checks against a transfer-level model.
module tb_axi_axis2bram;

    localparam int DW = 512;
    localparam int SW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_as2b_start;
    logic          o_as2b_done;
    logic [SW-1:0] i_as2b_data_size_bytes;
    logic          o_as2b_err;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tlast;
    logic [AW-1:0] o_as2b_wraddr;
    logic [DW-1:0] o_as2b_wrdata;
    logic          o_as2b_wren;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [AW-1:0] mon_addr[$];
    logic [DW-1:0] mon_data[$];
    int            mon_cyc[$];

    axi_axis2bram #(
        .AXI_DATA_WIDTH     (DW),
        .AXI_XFER_SIZE_WIDTH(SW),
        .BRAM_ADDR_WIDTH    (AW),
        .BRAM_DATA_WIDTH    (DW)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .i_as2b_start          (i_as2b_start),
        .o_as2b_done           (o_as2b_done),
        .i_as2b_data_size_bytes(i_as2b_data_size_bytes),
        .o_as2b_err            (o_as2b_err),
        .s_axis_tvalid         (s_axis_tvalid),
        .s_axis_tready         (s_axis_tready),
        .s_axis_tdata          (s_axis_tdata),
        .s_axis_tlast          (s_axis_tlast),
        .o_as2b_wraddr         (o_as2b_wraddr),
        .o_as2b_wrdata         (o_as2b_wrdata),
        .o_as2b_wren           (o_as2b_wren)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM port monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (o_as2b_wren === 1'b1) begin
            mon_addr.push_back(o_as2b_wraddr);
            mon_data.push_back(o_as2b_wrdata);
            mon_cyc.push_back(cyc);
        end
    end

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] r;
        for (int w = 0; w < DW / 32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_clear();
        mon_addr.delete();
        mon_data.delete();
        mon_cyc.delete();
    endtask

    task automatic do_start(input logic [SW-1:0] sz);
        i_as2b_start           = 1'b1;
        i_as2b_data_size_bytes = sz;
        tick();
        i_as2b_start = 1'b0;
    endtask

    // Present one beat for up to budget cycles; hs_cyc is the cycle number after the accepting edge.
    task automatic send_beat(input logic [DW-1:0] d, input logic last, input int budget,
                             output logic acc, output int hs_cyc);
        acc           = 1'b0;
        hs_cyc        = -1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        for (int k = 0; k < budget; k++) begin
            if (s_axis_tready === 1'b1) begin
                tick();
                acc    = 1'b1;
                hs_cyc = cyc;
                break;
            end
            tick();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (o_as2b_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        #3;
        total++; if (o_as2b_done !== 1'b1) begin bad++; $display("FAIL reset_done got=%b exp=1", o_as2b_done); end
        total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL reset_tready got=%b exp=0", s_axis_tready); end
        total++; if (o_as2b_wren !== 1'b0) begin bad++; $display("FAIL reset_wren got=%b exp=0", o_as2b_wren); end
        total++; if (o_as2b_wraddr !== '0) begin bad++; $display("FAIL reset_wraddr got=%h exp=0", o_as2b_wraddr); end
        total++; if (o_as2b_wrdata !== '0) begin bad++; $display("FAIL reset_wrdata got=%h exp=0", o_as2b_wrdata); end
        total++; if (o_as2b_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", o_as2b_err); end
        #10;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [DW-1:0] d[4];
        int            hs[4];
        logic          acc;
        int            nacc = 0;
        mon_clear();
        do_start(256);
        for (int i = 0; i < 4; i++) begin
            d[i] = rand_beat();
            send_beat(d[i], i == 3, 10, acc, hs[i]);
            if (acc) nacc++;
        end
        total++; if (nacc != 4) begin bad++; $display("FAIL basic_accepted got=%0d exp=4", nacc); end
        total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL basic_tready_release got=%b exp=0", s_axis_tready); end
        total++; if (o_as2b_done !== 1'b0) begin bad++; $display("FAIL basic_done_in_flush got=%b exp=0", o_as2b_done); end
        tick();
        total++; if (o_as2b_done !== 1'b1) begin bad++; $display("FAIL basic_done_latency got=%b exp=1", o_as2b_done); end
        total++; if (mon_addr.size() != 4) begin bad++; $display("FAIL basic_nwrites got=%0d exp=4", mon_addr.size()); end
        for (int i = 0; i < 4 && i < mon_addr.size(); i++) begin
            total++;
            if (mon_addr[i] !== AW'(i) || mon_data[i] !== d[i] || mon_cyc[i] != hs[0] + i) begin
                bad++;
                $display("FAIL basic_write%0d got addr=%0d cyc=%0d exp addr=%0d cyc=%0d data_ok=%0d",
                         i, mon_addr[i], mon_cyc[i], i, hs[0] + i, mon_data[i] === d[i]);
            end
        end
    endtask

    task automatic test_gapped();
        logic [DW-1:0] d[4];
        int            hs[4];
        logic          acc;
        logic          ok;
        int            nacc = 0;
        mon_clear();
        do_start(256);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                s_axis_tvalid = 1'b0;
                tick();
            end
            d[i] = rand_beat();
            send_beat(d[i], i == 3, 10, acc, hs[i]);
            if (acc) nacc++;
        end
        wait_done(10, ok);
        total++; if (!ok || nacc != 4) begin bad++; $display("FAIL gap_complete got done=%b acc=%0d exp done=1 acc=4", ok, nacc); end
        total++; if (mon_addr.size() != 4) begin bad++; $display("FAIL gap_nwrites got=%0d exp=4", mon_addr.size()); end
        for (int i = 0; i < 4 && i < mon_addr.size(); i++) begin
            total++;
            if (mon_addr[i] !== AW'(i) || mon_data[i] !== d[i] || mon_cyc[i] != hs[0] + 2 * i) begin
                bad++;
                $display("FAIL gap_write%0d got addr=%0d cyc=%0d exp addr=%0d cyc=%0d data_ok=%0d",
                         i, mon_addr[i], mon_cyc[i], i, hs[0] + 2 * i, mon_data[i] === d[i]);
            end
        end
    endtask

    task automatic test_zero();
        mon_clear();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = rand_beat();
        s_axis_tlast  = 1'b1;
        do_start(0);
        total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL zero_tready got=%b exp=0", s_axis_tready); end
        total++; if (o_as2b_done !== 1'b0) begin bad++; $display("FAIL zero_done_early got=%b exp=0", o_as2b_done); end
        tick();
        total++; if (o_as2b_done !== 1'b1) begin bad++; $display("FAIL zero_done_latency got=%b exp=1", o_as2b_done); end
        tick();
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        total++; if (mon_addr.size() != 0) begin bad++; $display("FAIL zero_nwrites got=%0d exp=0", mon_addr.size()); end
    endtask

    task automatic test_truncated();
        logic [DW-1:0] d0, d1;
        logic          acc0, acc1, ok;
        int            h0, h1;
        mon_clear();
        do_start(100);
        d0 = rand_beat();
        d1 = rand_beat();
        send_beat(d0, 1'b1, 5, acc0, h0);
        send_beat(d1, 1'b1, 5, acc1, h1);
        wait_done(10, ok);
        total++; if (acc0 !== 1'b1 || acc1 !== 1'b0) begin bad++; $display("FAIL trunc_accept got=%b%b exp=10", acc0, acc1); end
        total++; if (!ok) begin bad++; $display("FAIL trunc_done got=0 exp=1"); end
        total++;
        if (mon_addr.size() != 1 || mon_addr[0] !== '0 || mon_data[0] !== d0) begin
            bad++;
            $display("FAIL trunc_write got n=%0d exp n=1 addr=0", mon_addr.size());
        end
    endtask

    task automatic test_tlast();
        logic [DW-1:0] d[4];
        logic          acc, ok;
        int            h;
        int            nacc = 0;
        mon_clear();
        do_start(256);
        for (int i = 0; i < 4; i++) d[i] = rand_beat();
`ifdef AXIS2BRAM_TLAST_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            send_beat(d[i], i == 1, 4, acc, h);
            if (acc) nacc++;
        end
        wait_done(10, ok);
        total++; if (nacc != 2 || !ok) begin bad++; $display("FAIL early_tlast_accept got=%0d done=%b exp=2 done=1", nacc, ok); end
        total++; if (o_as2b_err !== 1'b1) begin bad++; $display("FAIL early_tlast_err got=%b exp=1", o_as2b_err); end
        total++;
        if (mon_addr.size() != 2 || mon_addr[0] !== AW'(0) || mon_addr[1] !== AW'(1) ||
            mon_data[0] !== d[0] || mon_data[1] !== d[1]) begin
            bad++;
            $display("FAIL early_tlast_writes got n=%0d exp n=2", mon_addr.size());
        end
        do_start(64);
        total++; if (o_as2b_err !== 1'b0) begin bad++; $display("FAIL err_clear_on_start got=%b exp=0", o_as2b_err); end
        send_beat(d[3], 1'b1, 5, acc, h);
        wait_done(10, ok);
        total++; if (o_as2b_err !== 1'b0 || !ok) begin bad++; $display("FAIL clean_tlast_err got=%b exp=0", o_as2b_err); end
        mon_clear();
        do_start(128);
        send_beat(d[0], 1'b0, 5, acc, h);
        send_beat(d[1], 1'b0, 5, acc, h);
        wait_done(10, ok);
        total++; if (o_as2b_err !== 1'b1) begin bad++; $display("FAIL missing_tlast_err got=%b exp=1", o_as2b_err); end
        total++; if (mon_addr.size() != 2) begin bad++; $display("FAIL missing_tlast_nwrites got=%0d exp=2", mon_addr.size()); end
`else
        for (int i = 0; i < 4; i++) begin
            send_beat(d[i], i == 1, 5, acc, h);
            if (acc) nacc++;
        end
        wait_done(10, ok);
        total++; if (nacc != 4 || !ok) begin bad++; $display("FAIL tlast_ignored_accept got=%0d done=%b exp=4 done=1", nacc, ok); end
        total++; if (o_as2b_err !== 1'b0) begin bad++; $display("FAIL tlast_ignored_err got=%b exp=0", o_as2b_err); end
        total++; if (mon_addr.size() != 4) begin bad++; $display("FAIL tlast_ignored_nwrites got=%0d exp=4", mon_addr.size()); end
        for (int i = 0; i < 4 && i < mon_addr.size(); i++) begin
            total++;
            if (mon_addr[i] !== AW'(i) || mon_data[i] !== d[i]) begin
                bad++;
                $display("FAIL tlast_ignored_write%0d got addr=%0d exp=%0d", i, mon_addr[i], i);
            end
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d[2];
        logic          acc, ok;
        int            h;
        do_start(256);
        send_beat(rand_beat(), 1'b0, 5, acc, h);
        send_beat(rand_beat(), 1'b0, 5, acc, h);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (o_as2b_wren !== 1'b0) begin bad++; $display("FAIL rstmid_wren got=%b exp=0", o_as2b_wren); end
        total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL rstmid_tready got=%b exp=0", s_axis_tready); end
        total++; if (o_as2b_done !== 1'b1) begin bad++; $display("FAIL rstmid_done got=%b exp=1", o_as2b_done); end
        rst_n = 1'b1;
        tick();
        mon_clear();
        do_start(128);
        for (int i = 0; i < 2; i++) begin
            d[i] = rand_beat();
            send_beat(d[i], i == 1, 5, acc, h);
        end
        wait_done(10, ok);
        total++;
        if (!ok || mon_addr.size() != 2 || mon_addr[0] !== AW'(0) || mon_addr[1] !== AW'(1) ||
            mon_data[0] !== d[0] || mon_data[1] !== d[1]) begin
            bad++;
            $display("FAIL rstmid_restart got n=%0d done=%b exp n=2 addr 0,1", mon_addr.size(), ok);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int            size;
            int            depth;
            int            nacc;
            int            h;
            logic          acc, ok;
            logic [DW-1:0] exp_data[$];
            size  = $urandom_range(0, 900);
            depth = (size * 8) / DW;
            nacc  = 0;
            mon_clear();
            do_start(SW'(size));
            for (int i = 0; i < depth; i++) begin
                logic [DW-1:0] d;
                if ($urandom_range(0, 1) == 1) begin
                    s_axis_tvalid = 1'b0;
                    repeat ($urandom_range(1, 2)) tick();
                end
                d = rand_beat();
                exp_data.push_back(d);
                send_beat(d, i == depth - 1, 10, acc, h);
                if (acc) nacc++;
            end
            wait_done(10, ok);
            total++; if (!ok || nacc != depth) begin bad++; $display("FAIL rand%0d_complete got acc=%0d done=%b exp acc=%0d done=1", it, nacc, ok, depth); end
            total++; if (mon_addr.size() != depth) begin bad++; $display("FAIL rand%0d_nwrites got=%0d exp=%0d", it, mon_addr.size(), depth); end
            total++; if (o_as2b_err !== 1'b0) begin bad++; $display("FAIL rand%0d_err got=%b exp=0", it, o_as2b_err); end
            for (int i = 0; i < depth && i < mon_addr.size(); i++) begin
                total++;
                if (mon_addr[i] !== AW'(i) || mon_data[i] !== exp_data[i]) begin
                    bad++;
                    $display("FAIL rand%0d_write%0d got addr=%0d exp=%0d data_ok=%0d",
                             it, i, mon_addr[i], i, mon_data[i] === exp_data[i]);
                end
            end
        end
    endtask

    initial begin
        rst_n                  = 1'b0;
        i_as2b_start           = 1'b0;
        i_as2b_data_size_bytes = '0;
        s_axis_tvalid          = 1'b0;
        s_axis_tdata           = '0;
        s_axis_tlast           = 1'b0;
        test_reset();
        test_basic();
        test_gapped();
        test_zero();
        test_truncated();
        test_tlast();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
